// File: rtl/i2s_writer.sv
// i2s_writer: serialises 24-bit samples from the I2S memory controller onto
// an I2S bus (SCLK, LRCLK, SDATA). One-sample look-ahead buffer is refilled
// over a four-phase request/ack handshake; underrun and channel-resync
// events are reported as sticky flags.
module i2s_writer (
  input  logic        rst,
  input  logic        clk,
  input  logic        enable,
  input  logic [7:0]  clock_divisor,
  input  logic        clear_status,
  output logic        audio_data_request,
  input  logic        audio_data_ack,
  input  logic [23:0] audio_data,
  input  logic        audio_lr_bit,
  output logic        i2s_sclk,
  output logic        i2s_lrclk,
  output logic        i2s_data,
  output logic        underrun,
  output logic        resync
);

  // SCLK divider state
  logic [7:0]  div_cnt;
  logic [7:0]  div_lim;
  logic        div_run;
  logic [7:0]  eff_lim;
  logic        div_wrap;
  logic        fall_tick;

  // slot / bit position state
  logic [5:0]  bit_cnt;
  logic [5:0]  bit_next;
  logic [31:0] shreg;

  // look-ahead buffer
  logic [23:0] buf_data;
  logic        buf_lr;
  logic        buf_valid;

  // slot-start decisions
  logic        load_slot;
  logic        buf_match;
  logic        consume;
  logic        set_underrun;
  logic        set_resync;
  logic        ack_take;

  // Decode divider wrap, falling SCLK toggles and what a slot start does
  // with the buffered sample.
  always_comb begin
    // The divisor is sampled at every wrap; before the first wrap after
    // enable rises the live input is used so the first edge lands
    // clock_divisor+1 cycles after enable.
    eff_lim      = div_run ? div_lim : clock_divisor;
    div_wrap     = enable && (div_cnt == eff_lim);
    fall_tick    = div_wrap && i2s_sclk;
    bit_next     = bit_cnt + 6'd1;
    load_slot    = fall_tick && (bit_next[4:0] == 5'd1);
    buf_match    = buf_valid && (buf_lr == bit_next[5]);
    consume      = load_slot && buf_match;
    set_underrun = load_slot && !buf_valid;
    set_resync   = load_slot && buf_valid && !buf_match;
    ack_take     = enable && audio_data_request && audio_data_ack;
  end

  // Bit-clock divider: toggles i2s_sclk every clock_divisor+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      div_lim  <= '0;
      div_run  <= 1'b0;
      i2s_sclk <= 1'b0;
    end else if (!enable) begin
      div_cnt  <= '0;
      div_lim  <= clock_divisor;
      div_run  <= 1'b0;
      i2s_sclk <= 1'b0;
    end else begin
      div_run <= 1'b1;
      if (div_wrap || !div_run) begin
        div_lim <= clock_divisor;
      end
      if (div_wrap) begin
        div_cnt  <= '0;
        i2s_sclk <= ~i2s_sclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

  // Bit counter, word select and output shift register, all updated on the
  // falling SCLK toggle; the load at b%32==1 gives the one-bit MSB delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= 6'd63;
      i2s_lrclk <= 1'b0;
      shreg     <= '0;
    end else if (!enable) begin
      bit_cnt   <= 6'd63;
      i2s_lrclk <= 1'b0;
      shreg     <= '0;
    end else if (fall_tick) begin
      bit_cnt   <= bit_next;
      i2s_lrclk <= bit_next[5];
      if (load_slot) begin
        shreg <= consume ? {buf_data, 8'h00} : '0;
      end else begin
        shreg <= {shreg[30:0], 1'b0};
      end
    end
  end

  // The serial data line is the top bit of the shift register, so it is
  // zero whenever the register is cleared.
  always_comb begin
    i2s_data = shreg[31];
  end

  // Look-ahead buffer and four-phase request/ack handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data           <= '0;
      buf_lr             <= 1'b0;
      buf_valid          <= 1'b0;
      audio_data_request <= 1'b0;
    end else if (!enable) begin
      buf_data           <= '0;
      buf_lr             <= 1'b0;
      buf_valid          <= 1'b0;
      audio_data_request <= 1'b0;
    end else if (ack_take) begin
      // A request is only outstanding with an empty buffer, so a load in
      // this same cycle has already seen valid=0 and cannot consume.
      buf_data           <= audio_data;
      buf_lr             <= audio_lr_bit;
      buf_valid          <= 1'b1;
      audio_data_request <= 1'b0;
    end else begin
      if (consume) begin
        buf_valid <= 1'b0;
      end
      if (!audio_data_request) begin
        audio_data_request <= !buf_valid && !audio_data_ack;
      end
    end
  end

  // Sticky status flags; a new event wins over clear_status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun <= 1'b0;
      resync   <= 1'b0;
    end else begin
      underrun <= set_underrun || (underrun && !clear_status);
      resync   <= set_resync   || (resync   && !clear_status);
    end
  end

endmodule

// File: tb/tb_i2s_writer.sv
// Testbench for i2s_writer: a behavioural memory controller feeds samples,
// an I2S receiver decodes the bus into words, and decoded words are
// compared with the sample stream the controller was given.
module tb_i2s_writer;

  logic        rst;
  logic        clk;
  logic        enable;
  logic [7:0]  clock_divisor;
  logic        clear_status;
  logic        audio_data_request;
  logic        audio_data_ack;
  logic [23:0] audio_data;
  logic        audio_lr_bit;
  logic        i2s_sclk;
  logic        i2s_lrclk;
  logic        i2s_data;
  logic        underrun;
  logic        resync;

  i2s_writer dut (
    .rst                (rst),
    .clk                (clk),
    .enable             (enable),
    .clock_divisor      (clock_divisor),
    .clear_status       (clear_status),
    .audio_data_request (audio_data_request),
    .audio_data_ack     (audio_data_ack),
    .audio_data         (audio_data),
    .audio_lr_bit       (audio_lr_bit),
    .i2s_sclk           (i2s_sclk),
    .i2s_lrclk          (i2s_lrclk),
    .i2s_data           (i2s_data),
    .underrun           (underrun),
    .resync             (resync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- controller model ----------------
  logic        ctrl_on;
  int          ctrl_lat;
  logic        c_ack, man_ack;
  logic [23:0] c_data, man_data;
  logic        c_lr, man_lr;
  logic [24:0] src_q[$];
  int          cg;

  assign audio_data_ack = ctrl_on ? c_ack  : man_ack;
  assign audio_data     = ctrl_on ? c_data : man_data;
  assign audio_lr_bit   = ctrl_on ? c_lr   : man_lr;

  initial begin
    c_ack = 1'b0; c_data = '0; c_lr = 1'b0;
  end

  // Serve each request from src_q after ctrl_lat cycles; hold ack until
  // the request drops.
  always begin
    @(posedge clk); #1;
    if (ctrl_on && enable && !rst && audio_data_request && src_q.size() > 0) begin
      for (int i = 0; i < ctrl_lat; i++) begin
        @(posedge clk); #1;
      end
      if (enable && audio_data_request) begin
        {c_lr, c_data} = src_q.pop_front();
        c_ack = 1'b1;
        cg = 0;
        do begin
          @(posedge clk); #1;
          cg++;
        end while (audio_data_request && cg < 50);
        c_ack  = 1'b0;
        c_data = '0;
      end
    end
  end

  // ---------------- I2S receiver ----------------
  logic        prev_sclk;
  logic        rx_started;
  logic        rx_lr;
  int          rx_pos;
  logic [31:0] rx_bits;
  logic [31:0] rx_q[$];
  int          cyc;
  int          last_rise;
  int          last_period;

  initial begin
    cyc = 0; last_rise = 0; last_period = 0;
    prev_sclk = 1'b0; rx_started = 1'b0; rx_lr = 1'b1; rx_pos = 0; rx_bits = '0;
  end

  // Decode words on rising SCLK: the sample after an LRCLK change is bit
  // position 0, the MSB is position 1.
  always @(negedge clk) begin
    cyc++;
    if (rst || !enable) begin
      prev_sclk  = 1'b0;
      rx_started = 1'b0;
      rx_lr      = 1'b1;
      rx_pos     = 0;
      last_rise  = 0;
    end else begin
      if (!i2s_sclk && prev_sclk) rx_started = 1'b1;
      if (i2s_sclk && !prev_sclk) begin
        if (last_rise != 0) last_period = cyc - last_rise;
        last_rise = cyc;
        if (rx_started) begin
          if (i2s_lrclk != rx_lr) begin
            rx_lr  = i2s_lrclk;
            rx_pos = 0;
          end else begin
            rx_pos++;
          end
          if (rx_pos >= 1 && rx_pos <= 31) rx_bits[31 - rx_pos] = i2s_data;
          if (rx_pos == 31) rx_q.push_back({rx_lr, rx_bits[30:0]});
        end
      end
      prev_sclk = i2s_sclk;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] exp_word(input logic lr, input logic [23:0] s);
    return {lr, s, 7'h00};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable       = 1'b0;
    ctrl_on      = 1'b1;
    man_ack      = 1'b0;
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    tick(3);
    src_q.delete();
    rx_q.delete();
  endtask

  task automatic wait_words(input int n);
    int g;
    g = 0;
    while (rx_q.size() < n && g < 20000) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("words_arrived", 32'(rx_q.size() >= n), 32'd1);
  endtask

  function automatic logic [31:0] bus_vec();
    return {26'd0, audio_data_request, i2s_sclk, i2s_lrclk, i2s_data, underrun, resync};
  endfunction

  typedef struct {
    logic [7:0]  div;
    logic [23:0] l;
    logic [23:0] r;
    int          period;
    logic [31:0] wl;
    logic [31:0] wr;
  } vec_t;

  vec_t tbl[3];

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] s0, s1, s2;
    logic [31:0] expq[$];
    int g, npairs;

    tbl[0] = '{div: 8'd1, l: 24'hABCDEF, r: 24'h123456, period: 4,
               wl: {1'b0, 24'hABCDEF, 7'h0}, wr: {1'b1, 24'h123456, 7'h0}};
    tbl[1] = '{div: 8'd0, l: 24'h800001, r: 24'h7FFFFE, period: 2,
               wl: {1'b0, 24'h800001, 7'h0}, wr: {1'b1, 24'h7FFFFE, 7'h0}};
    tbl[2] = '{div: 8'd3, l: 24'hFFFFFF, r: 24'h5A5A5A, period: 8,
               wl: {1'b0, 24'hFFFFFF, 7'h0}, wr: {1'b1, 24'h5A5A5A, 7'h0}};

    rst = 1'b1; enable = 1'b0; clock_divisor = 8'd1; clear_status = 1'b0;
    ctrl_on = 1'b1; ctrl_lat = 1; man_ack = 1'b0; man_data = '0; man_lr = 1'b0;
    tick(3);
    check("reset_outputs", bus_vec(), 32'd0);
    rst = 1'b0;
    tick(2);

    // table-driven basic frames
    for (int k = 0; k < 3; k++) begin
      idle();
      clock_divisor = tbl[k].div;
      ctrl_lat = 1;
      src_q.push_back({1'b0, tbl[k].l});
      src_q.push_back({1'b1, tbl[k].r});
      enable = 1'b1;
      wait_words(2);
      check("sclk_period", 32'(last_period), 32'(tbl[k].period));
      check("left_word", word(0), tbl[k].wl);
      check("right_word", word(1), tbl[k].wr);
      check("flags_clean", {30'd0, underrun, resync}, 32'd0);
    end

    // underrun: nothing supplied for the first frame
    idle();
    clock_divisor = 8'd3;
    ctrl_lat = 0;
    enable = 1'b1;
    wait_words(1);
    check("underrun_left_zero", word(0), 32'd0);
    check("underrun_set", {31'd0, underrun}, 32'd1);
    wait_words(2);
    check("underrun_right_zero", word(1), {1'b1, 31'd0});
    src_q.push_back({1'b0, 24'h13579B});
    src_q.push_back({1'b1, 24'h2468AC});
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    tick(1);
    check("underrun_cleared", {30'd0, underrun, resync}, 32'd0);
    wait_words(4);
    check("after_underrun_l", word(2), exp_word(1'b0, 24'h13579B));
    check("after_underrun_r", word(3), exp_word(1'b1, 24'h2468AC));
    check("underrun_stays_clear", {31'd0, underrun}, 32'd0);

    // resync: first sample is tagged right
    idle();
    clock_divisor = 8'd1;
    ctrl_lat = 0;
    src_q.push_back({1'b1, 24'hC0FFEE});
    src_q.push_back({1'b0, 24'h111111});
    src_q.push_back({1'b1, 24'h222222});
    enable = 1'b1;
    wait_words(4);
    check("resync_left_zero", word(0), 32'd0);
    check("resync_right_held", word(1), exp_word(1'b1, 24'hC0FFEE));
    check("resync_aligned_l", word(2), exp_word(1'b0, 24'h111111));
    check("resync_aligned_r", word(3), exp_word(1'b1, 24'h222222));
    check("resync_flags", {30'd0, underrun, resync}, 32'd1);

    // handshake: ack held high for 5 cycles with a load inside the window
    idle();
    ctrl_on = 1'b0;
    clock_divisor = 8'd0;
    enable = 1'b1;
    g = 0;
    do begin
      tick(1);
      g++;
    end while (!audio_data_request && g < 50);
    check("hs_request_up", {31'd0, audio_data_request}, 32'd1);
    man_lr = 1'b0; man_data = 24'h3C3C3C; man_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (i == 0) man_data = 24'hFFFFFF;
      check("hs_request_low_during_ack", {31'd0, audio_data_request}, 32'd0);
    end
    man_ack = 1'b0;
    tick(1);
    check("hs_request_after_ack_low", {31'd0, audio_data_request}, 32'd1);
    wait_words(1);
    check("hs_single_sample", word(0), exp_word(1'b0, 24'h3C3C3C));

    // enable drop mid-slot at b=17
    idle();
    clock_divisor = 8'd1;
    ctrl_lat = 0;
    src_q.push_back({1'b0, 24'hAAAAAA});
    src_q.push_back({1'b1, 24'h555555});
    src_q.push_back({1'b0, 24'h0F0F0F});
    enable = 1'b1;
    g = 0;
    while (!(rx_started && rx_lr == 1'b0 && rx_pos == 17) && g < 2000) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drop_reached_b17", 32'(g < 2000), 32'd1);
    enable = 1'b0;
    tick(1);
    check("drop_bus_idle", bus_vec() & 32'h3C, 32'd0);
    tick(3);
    src_q.delete();
    rx_q.delete();
    src_q.push_back({1'b0, 24'h876543});
    src_q.push_back({1'b1, 24'h0ABCDE});
    enable = 1'b1;
    wait_words(2);
    check("reenable_left", word(0), exp_word(1'b0, 24'h876543));
    check("reenable_right", word(1), exp_word(1'b1, 24'h0ABCDE));
    check("reenable_flags", {30'd0, underrun, resync}, 32'd0);

    // asynchronous reset between clock edges mid-frame
    idle();
    clock_divisor = 8'd2;
    enable = 1'b1;
    wait_words(1);
    check("pre_reset_underrun", {31'd0, underrun}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", bus_vec(), 32'd0);
    tick(2);
    rx_q.delete();
    src_q.push_back({1'b0, 24'h654321});
    src_q.push_back({1'b1, 24'hFEDCBA});
    rst = 1'b0;
    wait_words(2);
    check("post_reset_left", word(0), exp_word(1'b0, 24'h654321));
    check("post_reset_right", word(1), exp_word(1'b1, 24'hFEDCBA));

    // randomized streams against the sample-order reference
    for (int it = 0; it < 5; it++) begin
      idle();
      clock_divisor = 8'($urandom_range(0, 3));
      ctrl_lat = $urandom_range(0, 1);
      npairs = $urandom_range(2, 4);
      expq.delete();
      for (int p = 0; p < npairs; p++) begin
        s0 = 24'($urandom);
        s1 = 24'($urandom);
        src_q.push_back({1'b0, s0});
        src_q.push_back({1'b1, s1});
        expq.push_back(exp_word(1'b0, s0));
        expq.push_back(exp_word(1'b1, s1));
      end
      enable = 1'b1;
      wait_words(2 * npairs);
      for (int w = 0; w < 2 * npairs; w++) begin
        check("rand_word", word(w), expq[w]);
      end
      s2 = 24'(2 * (clock_divisor + 1));
      check("rand_period", 32'(last_period), {8'd0, s2});
      check("rand_flags", {30'd0, underrun, resync}, 32'd0);
    end

    enable = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_writer.md
# i2s_writer

Serialises 24-bit audio samples from the I2S memory controller onto a standard I2S bus (SCLK, LRCLK, SDATA). Sits directly downstream of the memory controller in the `i2s_clock` domain. It pulls one sample per channel slot over a four-phase request/ack handshake and keeps a one-sample look-ahead buffer. Underrun and channel-resync events are reported as sticky status flags.

## Interface
- rst  in  1  asynchronous, active-high reset
- clk  in  1  `i2s_clock` domain clock; all logic is posedge clk
- enable  in  1  run; low idles the bus and flushes the look-ahead buffer
- clock_divisor  in  8  SCLK half-period = clock_divisor+1 clk cycles
- clear_status  in  1  single-cycle pulse; clears underrun and resync
- audio_data_request  out  1  request for next sample
- audio_data_ack  in  1  controller ack; data valid while high
- audio_data  in  24  signed sample, MSB first on the wire
- audio_lr_bit  in  1  0 = left, 1 = right
- i2s_sclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left
- i2s_data  out  1  serial data
- underrun  out  1  sticky: a slot started with no valid sample
- resync  out  1  sticky: a slot started with a sample for the wrong channel

## Operation
- **Divider**
  - 8-bit counter runs while enable=1; on reaching clock_divisor it resets to 0 and i2s_sclk toggles.
  - Divisor changes take effect at the next wrap.
- **Bit counter**
  - 6-bit counter b advances on each SCLK falling toggle (1→0), modulo 64.
  - Set to 63 when enable=0, so the first falling edge yields b=0.
- **Slot outputs**
  - i2s_lrclk is registered as b[5] at each falling toggle.
  - **Load:** at a falling toggle where b%32==1, the 32-bit shift register loads {sample, 8'h00} and i2s_data = bit 31.
  - **Shift:** at every other falling toggle the register shifts left and i2s_data = the new bit 31.
  - This gives the I2S one-bit MSB delay after an LRCLK edge.
- **Look-ahead buffer** (24-bit data + lr + valid)
  - At a load with valid=1 and lr == b[5]: consume the sample and clear valid.
  - valid=0 at load: shift zeros and set underrun.
  - valid=1 but lr != b[5]: shift zeros, keep the sample, and set resync. The held sample plays in the next slot, which realigns the channels.
- **Handshake** (four-phase)
  - Raise audio_data_request when valid=0, enable=1 and audio_data_ack=0.
  - On ack=1 while request=1: latch data and lr, set valid, drop request.
  - Do not re-raise request until ack has been observed low.
- **Status flags**
  - Set has priority over clear_status in the same cycle.
- **enable deasserted**
  - Next cycle: request=0, valid=0, sclk/lrclk/data=0, counters reinitialised.
  - Any ack arriving while enable=0 is ignored.

## Timing
- **Reset values:** all outputs 0 (request, sclk, lrclk, data, underrun, resync). Internal: b=63, divider=0, valid=0.
- **SCLK:** period = 2·(clock_divisor+1) clk cycles; frame = 64 SCLK periods.
- **Request:** rises 1 cycle after valid falls. Data is latched in the cycle ack is sampled high.
- **First SCLK edge:** rising, clock_divisor+1 cycles after enable rises.
- **First MSB:** appears on the 2nd falling edge (b=1).
- **Timing budget:** the controller needs 3 cycles from ack low to a new ack. With clock_divisor=0 there are ≥3 cycles between loads, which is enough.
- **Simultaneous ack and load in one cycle:** the load sees the old valid state and the ack fills the buffer afterwards.
- **Reset mid-frame:** all state clears immediately and asynchronously.

## Test plan
- **Basic frame:** divisor=1, controller returns L=0xABCDEF (lr0) and R=0x123456 (lr1). Required: SCLK period 4 clk; LRCLK low for 32 bits; data bits 1..24 after the LRCLK fall = 0xABCDEF MSB-first; 8 zero bits follow; the right slot carries 0x123456.
- **Underrun:** ack withheld for the first frame. Required: all data bits 0, underrun=1 from the b=1 load. clear_status → 0. Normal samples then play.
- **Resync:** first sample supplied has lr=1. Required: left slot zeros, resync=1; that sample plays in the right slot; following slots are correctly aligned.
- **Handshake protocol:** ack held high 5 cycles. Required: exactly one sample latched; request stays low until ack falls, then rises next cycle.
- **Enable drop:** enable=0 mid-slot (b=17). Required: next cycle all bus outputs 0 and request 0. After re-enable, the first MSB appears at b=1 of a fresh frame.
- **Async reset:** rst pulsed between clk edges mid-frame. Required: outputs 0 immediately; normal restart after release.
